// File: rtl/pac_sprite_pkg.sv
// Shared sprite geometry, plotter states and the Pac-Man animation frames
// used by both the frame shifter and the sprite plotter.
package pac_sprite_pkg;

  localparam int SPRITE_W    = 5;
  localparam int SPRITE_H    = 5;
  localparam int SPRITE_BITS = SPRITE_W * SPRITE_H;
  localparam int COL_W       = $clog2(SPRITE_W);
  localparam int ROW_W       = $clog2(SPRITE_H);
  localparam int BIT_IDX_W   = $clog2(SPRITE_BITS);

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } plot_state_t;

  // Row 0 column 0 lives in the MSB so the bitmap reads like the picture.
  function automatic logic [BIT_IDX_W-1:0] bit_index(input logic [ROW_W-1:0] r,
                                                     input logic [COL_W-1:0] c);
    return BIT_IDX_W'(SPRITE_BITS - 1 - SPRITE_W * int'(r) - int'(c));
  endfunction

  localparam logic [SPRITE_BITS-1:0] PAC_RIGHT_A = 25'b01110_11111_11000_11111_01110;
  localparam logic [SPRITE_BITS-1:0] PAC_RIGHT_B = 25'b01110_11110_11100_11110_01110;
  localparam logic [SPRITE_BITS-1:0] PAC_UP_A    = 25'b01010_11011_11111_11111_01110;
  localparam logic [SPRITE_BITS-1:0] PAC_UP_B    = 25'b01110_11011_11111_11111_01110;
  localparam logic [SPRITE_BITS-1:0] PAC_LEFT_A  = 25'b01110_11111_00011_11111_01110;
  localparam logic [SPRITE_BITS-1:0] PAC_LEFT_B  = 25'b01110_01111_00111_01111_01110;
  localparam logic [SPRITE_BITS-1:0] PAC_DOWN_A  = 25'b01110_11111_11111_11011_01010;
  localparam logic [SPRITE_BITS-1:0] PAC_DOWN_B  = 25'b01110_11111_11111_11011_01110;

endpackage

// File: rtl/sprite_raster_counter.sv
// Column/row walker over the sprite in raster order; wraps back to (0,0)
// after the last pixel so the plotter always starts from a clean origin.
module sprite_raster_counter
  import pac_sprite_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             last_pixel
);

  logic col_last;
  logic row_last;

  assign col_last   = (col == COL_W'(SPRITE_W - 1));
  assign row_last   = (row == ROW_W'(SPRITE_H - 1));
  assign last_pixel = col_last && row_last;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/sprite_plotter.sv
// Streams a latched 5x5 sprite to the VGA write port, one pixel per clock.
// Build option SPRITE_BG_FILL_EN: plot 0-bits in bg_colour instead of skipping them.
module sprite_plotter
  import pac_sprite_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [SPRITE_BITS-1:0] sprite,
  input  logic [X_W-1:0]         origin_x,
  input  logic [Y_W-1:0]         origin_y,
  input  logic [COLOUR_W-1:0]    colour,
  input  logic [COLOUR_W-1:0]    bg_colour,
  output logic [X_W-1:0]         x,
  output logic [Y_W-1:0]         y,
  output logic [COLOUR_W-1:0]    colour_out,
  output logic                   plot,
  output logic                   busy,
  output logic                   done
);

  plot_state_t state, state_next;

  logic [SPRITE_BITS-1:0] sprite_q;
  logic [X_W-1:0]         ox_q;
  logic [Y_W-1:0]         oy_q;
  logic [COLOUR_W-1:0]    fg_q;
  logic                   tail_q, tail_next;

  logic             latch, emit, clear_cnt, advance;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             last_pixel;

  logic [SPRITE_BITS-1:0] src_sprite;
  logic [X_W-1:0]         src_ox;
  logic [Y_W-1:0]         src_oy;
  logic [COLOUR_W-1:0]    src_fg;
  logic                   pix_bit;

  logic [X_W-1:0]      x_next;
  logic [Y_W-1:0]      y_next;
  logic [COLOUR_W-1:0] colour_next;
  logic                plot_next, busy_next, done_next;

  sprite_raster_counter u_counter (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear_cnt),
    .advance    (advance),
    .col        (col),
    .row        (row),
    .last_pixel (last_pixel)
  );

  // Pixel 0 is emitted on the accepting edge, so it reads the live inputs.
  assign src_sprite = latch ? sprite   : sprite_q;
  assign src_ox     = latch ? origin_x : ox_q;
  assign src_oy     = latch ? origin_y : oy_q;
  assign src_fg     = latch ? colour   : fg_q;
  assign pix_bit    = src_sprite[bit_index(row, col)];

`ifdef SPRITE_BG_FILL_EN
  logic [COLOUR_W-1:0] bg_q;
  logic [COLOUR_W-1:0] src_bg;

  assign src_bg = latch ? bg_colour : bg_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bg_q <= '0;
    end else if (latch) begin
      bg_q <= bg_colour;
    end
  end
`else
  logic unused_bg;

  assign unused_bg = ^bg_colour;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sprite_q <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      fg_q     <= '0;
    end else if (latch) begin
      sprite_q <= sprite;
      ox_q     <= origin_x;
      oy_q     <= origin_y;
      fg_q     <= colour;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tail_q     <= 1'b0;
      x          <= '0;
      y          <= '0;
      colour_out <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      tail_q     <= tail_next;
      x          <= x_next;
      y          <= y_next;
      colour_out <= colour_next;
      plot       <= plot_next;
      busy       <= busy_next;
      done       <= done_next;
    end
  end

  // tail_q marks the extra DRAW cycle after the last pixel that raises done.
  always_comb begin
    state_next  = state;
    tail_next   = tail_q;
    latch       = 1'b0;
    emit        = 1'b0;
    clear_cnt   = 1'b0;
    advance     = 1'b0;
    busy_next   = busy;
    done_next   = 1'b0;
    x_next      = x;
    y_next      = y;
    colour_next = colour_out;
    plot_next   = 1'b0;

    case (state)
      IDLE: begin
        busy_next = 1'b0;
        tail_next = 1'b0;
        if (start) begin
          latch      = 1'b1;
          emit       = 1'b1;
          advance    = 1'b1;
          busy_next  = 1'b1;
          state_next = DRAW;
        end else begin
          clear_cnt = 1'b1;
        end
      end
      DRAW: begin
        if (tail_q) begin
          state_next = IDLE;
          tail_next  = 1'b0;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end else begin
          emit      = 1'b1;
          advance   = 1'b1;
          tail_next = last_pixel;
        end
      end
      default: state_next = IDLE;
    endcase

    if (emit) begin
      x_next = src_ox + X_W'(col);
      y_next = src_oy + Y_W'(row);
`ifdef SPRITE_BG_FILL_EN
      plot_next   = 1'b1;
      colour_next = pix_bit ? src_fg : src_bg;
`else
      plot_next   = pix_bit;
      colour_next = src_fg;
`endif
    end
  end

endmodule
